// File: rtl/ask_keyer_pkg.sv
// Shared types and default constants for the ASK keyer and its neighbours.
package ask_keyer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_DATA  = 2'd2,
        ST_GUARD = 2'd3
    } ask_state_e;

    localparam int unsigned          ASK_WORD_W       = 12;
    localparam int unsigned          ASK_PRE_W        = 4;
    localparam logic [ASK_PRE_W-1:0] ASK_PREAMBLE     = 4'b1010;
    localparam int unsigned          ASK_GUARD_BITS   = 2;
    localparam int unsigned          ASK_CLKS_PER_BIT = 16;
    localparam int unsigned          ASK_CARRIER_DIV  = 2;

    // Width of a counter that runs 0..max_count-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ask_keyer_if.sv
// Serial word input and keyed-carrier status bundle of the ASK keyer.
interface ask_keyer_if;

    logic bit_in;
    logic bit_valid;
    logic word_start;
    logic ask_out;
    logic carrier_en;
    logic tx_busy;
    logic frame_done;
    logic overflow;

    // Upstream bit source / downstream consumer of the keyed waveform.
    modport master (
        output bit_in, bit_valid, word_start,
        input  ask_out, carrier_en, tx_busy, frame_done, overflow
    );

    // The keyer itself.
    modport slave (
        input  bit_in, bit_valid, word_start,
        output ask_out, carrier_en, tx_busy, frame_done, overflow
    );

endinterface

// File: rtl/ask_carrier_div.sv
// Square-wave carrier: phase toggles every CARRIER_DIV clocks while enabled.
module ask_carrier_div
    import ask_keyer_pkg::*;
#(
    parameter int unsigned CARRIER_DIV = ASK_CARRIER_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_phase
);

    localparam int unsigned CW = cnt_width(CARRIER_DIV);

    logic [CW-1:0] r_cnt;
    logic          r_phase;

    // Half-period counter; cleared whenever disabled so each burst starts at phase 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == CW'(CARRIER_DIV - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Masked so the first idle clock after a frame never shows a stale phase.
    assign o_phase = r_phase & i_en;

endmodule

// File: rtl/ask_keyer.sv
// ASK keyer: reassembles serial words, frames them as preamble + data + guard
// and on-off keys a square-wave carrier with the resulting symbol stream.
module ask_keyer
    import ask_keyer_pkg::*;
#(
    parameter int unsigned      WORD_W       = ASK_WORD_W,
    parameter int unsigned      PRE_W        = ASK_PRE_W,
    parameter logic [PRE_W-1:0] PREAMBLE     = ASK_PREAMBLE,
    parameter int unsigned      GUARD_BITS   = ASK_GUARD_BITS,
    parameter int unsigned      CLKS_PER_BIT = ASK_CLKS_PER_BIT,
    parameter int unsigned      CARRIER_DIV  = ASK_CARRIER_DIV
) (
    input logic        clk,
    input logic        rst,
    ask_keyer_if.slave bus
);

    localparam int unsigned SYM_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IDX_W = cnt_width(max3(PRE_W, WORD_W, GUARD_BITS));
    localparam int unsigned COL_W = $clog2(WORD_W + 1);
    localparam int unsigned REV_N = 1 << IDX_W;

    ask_state_e        r_state;
    logic [SYM_W-1:0]  r_sym_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_tx_sr;
    logic [WORD_W-1:0] r_col_sr;
    logic [COL_W-1:0]  r_col_cnt;
    logic [WORD_W-1:0] r_hold;
    logic              r_hold_valid;
    logic              r_overflow;
    logic              r_ask_out;

    logic              w_sym_tc;
    logic              w_frame_end;
    logic              w_consume;
    logic              w_complete;
    logic [WORD_W-1:0] w_word;
    logic              w_busy;
    logic              w_phase;
    logic              w_carrier_en;
    logic [REV_N-1:0]  w_pre_rev;

    // Preamble reversed so the symbol index selects it directly; padded to the
    // full index range so the select is always in bounds.
    for (genvar gi = 0; gi < REV_N; gi++) begin : g_pre_rev
        if (gi < PRE_W) begin : g_bit
            assign w_pre_rev[gi] = PREAMBLE[PRE_W-1-gi];
        end else begin : g_pad
            assign w_pre_rev[gi] = 1'b0;
        end
    end

    assign w_sym_tc    = (r_sym_cnt == SYM_W'(CLKS_PER_BIT - 1));
    assign w_frame_end = (r_state == ST_GUARD) && (r_idx == IDX_W'(GUARD_BITS - 1)) && w_sym_tc;
    assign w_consume   = r_hold_valid && ((r_state == ST_IDLE) || w_frame_end);
    assign w_word      = {r_col_sr[WORD_W-2:0], bus.bit_in};
    assign w_complete  = bus.bit_valid && !bus.word_start && (r_col_cnt == COL_W'(WORD_W - 1));
    assign w_busy      = (r_state != ST_IDLE);

    // Collector: word_start always restarts; count == WORD_W means no word in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_sr  <= '0;
            r_col_cnt <= COL_W'(WORD_W);
        end else if (bus.bit_valid) begin
            if (bus.word_start) begin
                r_col_sr  <= {{(WORD_W-1){1'b0}}, bus.bit_in};
                r_col_cnt <= COL_W'(1);
            end else if (r_col_cnt < COL_W'(WORD_W)) begin
                r_col_sr  <= w_word;
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    // Single-entry hold register; a word completing while it is still full is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_overflow <= w_complete && r_hold_valid && !w_consume;
            if (w_complete && (!r_hold_valid || w_consume)) begin
                r_hold       <= w_word;
                r_hold_valid <= 1'b1;
            end else if (w_consume) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Framing FSM: symbol timer, symbol index and transmit shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_sym_cnt <= '0;
            r_idx     <= '0;
            r_tx_sr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_hold_valid) begin
                        r_state   <= ST_PRE;
                        r_sym_cnt <= '0;
                        r_idx     <= '0;
                        r_tx_sr   <= r_hold;
                    end
                end
                default: begin
                    if (!w_sym_tc) begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end else begin
                        r_sym_cnt <= '0;
                        r_idx     <= r_idx + 1'b1;
                        case (r_state)
                            ST_PRE: begin
                                if (r_idx == IDX_W'(PRE_W - 1)) begin
                                    r_state <= ST_DATA;
                                    r_idx   <= '0;
                                end
                            end
                            ST_DATA: begin
                                r_tx_sr <= {r_tx_sr[WORD_W-2:0], 1'b0};
                                if (r_idx == IDX_W'(WORD_W - 1)) begin
                                    r_state <= ST_GUARD;
                                    r_idx   <= '0;
                                end
                            end
                            ST_GUARD: begin
                                if (r_idx == IDX_W'(GUARD_BITS - 1)) begin
                                    r_idx <= '0;
                                    if (r_hold_valid) begin
                                        r_state <= ST_PRE;
                                        r_tx_sr <= r_hold;
                                    end else begin
                                        r_state <= ST_IDLE;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Symbol value decoded purely from state registers, so it cannot glitch.
    always_comb begin
        w_carrier_en = 1'b0;
        case (r_state)
            ST_PRE:  w_carrier_en = w_pre_rev[r_idx];
            ST_DATA: w_carrier_en = r_tx_sr[WORD_W-1];
            default: w_carrier_en = 1'b0;
        endcase
    end

    ask_carrier_div #(
        .CARRIER_DIV (CARRIER_DIV)
    ) u_carrier_div (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_busy),
        .o_phase (w_phase)
    );

    // Keyed carrier output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ask_out <= 1'b0;
        end else begin
            r_ask_out <= w_phase & w_carrier_en;
        end
    end

    assign bus.ask_out    = r_ask_out;
    assign bus.carrier_en = w_carrier_en;
    assign bus.tx_busy    = w_busy;
    assign bus.frame_done = w_frame_end;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_ask_keyer.sv
// Randomized self-checking bench for ask_keyer against a frame-schedule model.
module tb_ask_keyer;
    import ask_keyer_pkg::*;

    localparam int CPB  = 4;
    localparam int DIV  = 2;
    localparam int W    = 12;
    localparam int PW   = 4;
    localparam int G    = 2;
    localparam int L    = (PW + W + G) * CPB;
    localparam int MAXT = 1024;
    localparam logic [15:0] PRE_PAT = 16'b1010;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ask_keyer_if kif ();

    ask_keyer #(.CLKS_PER_BIT(CPB), .CARRIER_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    always #5 clk = ~clk;

    logic       s_v  [MAXT];
    logic       s_b  [MAXT];
    logic       s_ws [MAXT];
    int         n_stim;
    logic       m_cen  [MAXT];
    logic       m_busy [MAXT];
    logic       m_done [MAXT];
    logic       m_ovf  [MAXT];
    logic [4:0] e_out  [MAXT];
    logic [4:0] obs;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic logic bit_at(input logic [15:0] v, input int n);
        return ((v >> n) & 16'd1) != 16'd0;
    endfunction

    task automatic push(input logic v, input logic b, input logic ws);
        s_v[n_stim] = v; s_b[n_stim] = b; s_ws[n_stim] = ws;
        n_stim++;
    endtask

    task automatic push_bits(input logic [11:0] w, input int nbits, input int gap_max);
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(gap_max, 0)) push(1'b0, 1'($urandom), 1'b0);
            push(1'b1, w[11-i], i == 0);
        end
    endtask

    task automatic push_idle(input int n, input logic ws_noise);
        repeat (n) push(1'b0, 1'($urandom), ws_noise & 1'($urandom));
    endtask

    task automatic push_junk(input int n);
        repeat (n) push(1'b1, 1'($urandom), 1'b0);
    endtask

    // Model: words complete on their last bit; a frame starts one clk after its word
    // is held, or straight after the previous frame; a word completing while an
    // earlier one is still waiting for the transmitter is lost.
    task automatic build_model(input int t_len);
        int cnt, free_at, pend_start, s, sym, run;
        logic [15:0] acc;
        logic ph, prev_ph, ask;
        cnt = W; acc = '0; free_at = 0; pend_start = -1; run = 0; prev_ph = 1'b0;
        for (int k = 0; k < t_len; k++) begin
            m_cen[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b0; m_ovf[k] = 1'b0;
        end
        for (int j = 0; j < n_stim; j++) begin
            if (s_v[j]) begin
                if (s_ws[j]) begin
                    acc = {15'b0, s_b[j]};
                    cnt = 1;
                end else if (cnt < W) begin
                    acc = {acc[14:0], s_b[j]};
                    cnt++;
                    if (cnt == W) begin
                        if (pend_start > j) begin
                            if (j < t_len) m_ovf[j] = 1'b1;
                        end else begin
                            s = (j + 1 > free_at) ? j + 1 : free_at;
                            free_at = s + L;
                            pend_start = s;
                            for (int k = s; k < s + L && k < t_len; k++) begin
                                sym = (k - s) / CPB;
                                m_busy[k] = 1'b1;
                                if (sym < PW)          m_cen[k] = bit_at(PRE_PAT, PW - 1 - sym);
                                else if (sym < PW + W) m_cen[k] = bit_at(acc, W - 1 - (sym - PW));
                                else                   m_cen[k] = 1'b0;
                                m_done[k] = (k == s + L - 1);
                            end
                        end
                    end
                end
            end
        end
        for (int k = 0; k < t_len; k++) begin
            if (m_busy[k] && (k == 0 || !m_busy[k-1])) run = k;
            ph  = m_busy[k] && ((((k - run) / DIV) % 2) == 1);
            ask = (k == 0) ? 1'b0 : (prev_ph & m_cen[k-1]);
            prev_ph = ph;
            e_out[k] = {ask, m_cen[k], m_busy[k], m_done[k], m_ovf[k]};
        end
    endtask

    task automatic step(input int k);
        if (k < n_stim) begin
            kif.bit_valid = s_v[k]; kif.bit_in = s_b[k]; kif.word_start = s_ws[k];
        end else begin
            kif.bit_valid = 1'b0; kif.bit_in = 1'b0; kif.word_start = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        obs = {kif.ask_out, kif.carrier_en, kif.tx_busy, kif.frame_done, kif.overflow};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        kif.bit_valid = 1'b0; kif.bit_in = 1'b0; kif.word_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n_stim = 0;
    endtask

    task automatic test_reset();
        int t_len;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            kif.bit_valid = 1'($urandom); kif.bit_in = 1'($urandom); kif.word_start = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            obs = {kif.ask_out, kif.carrier_en, kif.tx_busy, kif.frame_done, kif.overflow};
            n_vec++;
            if (obs !== 5'b0) begin
                n_err++;
                $display("FAIL reset_held cyc %0d out=%b exp=%b", k, obs, 5'b0);
            end
        end
        rst = 1'b1;
        n_stim = 0;
        push_junk(20);
        push_idle(6, 1'b0);
        push_junk(14);
        t_len = n_stim + 10;
        build_model(t_len);
        for (int k = 0; k < t_len; k++) begin
            step(k);
            n_vec++;
            if (obs !== e_out[k]) begin
                n_err++;
                $display("FAIL reset_release cyc %0d out=%b exp=%b", k, obs, e_out[k]);
            end
        end
    endtask

    task automatic test_single_word();
        int t_len, dones;
        do_reset();
        push_bits(12'hA5C, 12, 0);
        t_len = n_stim + L + 8;
        build_model(t_len);
        dones = 0;
        for (int k = 0; k < t_len; k++) begin
            step(k);
            dones += int'(kif.frame_done);
            n_vec++;
            if (obs !== e_out[k]) begin
                n_err++;
                $display("FAIL single_word cyc %0d out=%b exp=%b", k, obs, e_out[k]);
            end
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL single_word_done_count got %0d exp 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        int t_len, falls;
        logic prev_busy;
        do_reset();
        push_bits(12'($urandom), 12, 0);
        push_idle(20, 1'b1);
        push_bits(12'($urandom), 12, 1);
        push_junk(5);
        t_len = n_stim + 2 * L;
        build_model(t_len);
        falls = 0; prev_busy = 1'b0;
        for (int k = 0; k < t_len; k++) begin
            step(k);
            if (prev_busy && !kif.tx_busy) falls++;
            prev_busy = kif.tx_busy;
            n_vec++;
            if (obs !== e_out[k]) begin
                n_err++;
                $display("FAIL back_to_back cyc %0d out=%b exp=%b", k, obs, e_out[k]);
            end
        end
        n_vec++;
        if (falls !== 1) begin
            n_err++;
            $display("FAIL back_to_back_busy_gaps got %0d exp 1", falls);
        end
    endtask

    task automatic test_overflow();
        int t_len, ovfs;
        do_reset();
        for (int i = 0; i < 3; i++) push_bits(12'($urandom), 12, 0);
        t_len = n_stim + 2 * L + 10;
        build_model(t_len);
        ovfs = 0;
        for (int k = 0; k < t_len; k++) begin
            step(k);
            ovfs += int'(kif.overflow);
            n_vec++;
            if (obs !== e_out[k]) begin
                n_err++;
                $display("FAIL overflow cyc %0d out=%b exp=%b", k, obs, e_out[k]);
            end
        end
        n_vec++;
        if (ovfs !== 1) begin
            n_err++;
            $display("FAIL overflow_pulse_count got %0d exp 1", ovfs);
        end
    endtask

    task automatic test_restart();
        int t_len;
        do_reset();
        push_bits(12'($urandom), 5, 1);
        push_idle(2, 1'b0);
        push_bits(12'h3F0, 12, 0);
        push_junk(4);
        t_len = n_stim + L + 8;
        build_model(t_len);
        for (int k = 0; k < t_len; k++) begin
            step(k);
            n_vec++;
            if (obs !== e_out[k]) begin
                n_err++;
                $display("FAIL restart cyc %0d out=%b exp=%b", k, obs, e_out[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        int t_len;
        do_reset();
        push_bits(12'($urandom), 12, 0);
        // word held at edge 11, PRE from cycle 12, DATA symbol 6 covers cycles 52..55
        t_len = 54;
        build_model(t_len);
        for (int k = 0; k < t_len; k++) begin
            step(k);
            n_vec++;
            if (obs !== e_out[k]) begin
                n_err++;
                $display("FAIL async_pre cyc %0d out=%b exp=%b", k, obs, e_out[k]);
            end
        end
        rst = 1'b0;
        #1;
        obs = {kif.ask_out, kif.carrier_en, kif.tx_busy, kif.frame_done, kif.overflow};
        n_vec++;
        if (obs !== 5'b0) begin
            n_err++;
            $display("FAIL async_reset_immediate out=%b exp=%b", obs, 5'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        n_stim = 0;
        push_junk(10);
        push_idle(5, 1'b0);
        push_bits(12'($urandom), 12, 1);
        t_len = n_stim + L + 8;
        build_model(t_len);
        for (int k = 0; k < t_len; k++) begin
            step(k);
            n_vec++;
            if (obs !== e_out[k]) begin
                n_err++;
                $display("FAIL async_post cyc %0d out=%b exp=%b", k, obs, e_out[k]);
            end
        end
    endtask

    task automatic test_random();
        int t_len;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 6; i++) begin
                case ($urandom_range(4, 0))
                    0, 1: push_bits(12'($urandom), 12, $urandom_range(3, 0));
                    2:    push_idle($urandom_range(40, 0), 1'b1);
                    3:    push_junk($urandom_range(6, 0));
                    default: push_bits(12'($urandom), $urandom_range(11, 1), 1);
                endcase
            end
            t_len = n_stim + 2 * L + 10;
            build_model(t_len);
            for (int k = 0; k < t_len; k++) begin
                step(k);
                n_vec++;
                if (obs !== e_out[k]) begin
                    n_err++;
                    $display("FAIL random_r%0d cyc %0d out=%b exp=%b", r, k, obs, e_out[k]);
                end
            end
        end
    endtask

    initial begin
        kif.bit_valid = 1'b0;
        kif.bit_in = 1'b0;
        kif.word_start = 1'b0;
        n_stim = 0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ask_keyer.md
Name: ask_keyer

Overview:
- Downstream stage of the modulator top.
- Consumes the serial whitened bit stream (result_out) and its word marker (new_word).
- Reassembles 12-bit words and frames each one as preamble + data + guard.
- On-off keys a square-wave carrier to produce the ASK transmit waveform.
- A single holding register decouples word arrival from symbol-rate transmission.

Parameters:
- WORD_W, 12: data bits per word, MSB first.
- PRE_W, 4: preamble length in symbols.
- PREAMBLE, 4'b1010: preamble pattern, sent MSB first.
- GUARD_BITS, 2: carrier-off symbols after each word.
- CLKS_PER_BIT, 16: clocks per symbol, >=2.
- CARRIER_DIV, 2: clocks per carrier half-period, >=1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- bit_in  in  1  serial data bit (from result_out).
- bit_valid  in  1  bit_in is sampled on every clk where this is 1.
- word_start  in  1  qualifies the current valid bit as bit 0 (MSB) of a new word (from new_word).
- ask_out  out  1  keyed carrier, registered.
- carrier_en  out  1  current symbol value; 1 = carrier on.
- tx_busy  out  1  1 whenever the FSM is not IDLE.
- frame_done  out  1  one-cycle pulse on the last clk of GUARD.
- overflow  out  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset: all outputs 0; FSM IDLE; collector count = WORD_W (idle, no word in progress); hold_valid 0; all counters 0.
- Collector, bit with word_start: on bit_valid && word_start, the shift register restarts with bit_in as MSB and count = 1. Any partial word is discarded silently.
- Collector, bit without word_start: on bit_valid && !word_start && count < WORD_W, shift the bit in and increment count. Such bits are ignored when count == WORD_W.
- Word completion: when count reaches WORD_W, the word moves to the hold register at the same edge and hold_valid is set.
- Overflow: if hold_valid is already 1 and not being consumed at that edge, the new word is dropped and overflow pulses.
- Simultaneous completion and consumption: the word is accepted and no overflow occurs.
- FSM states: IDLE, PRE, DATA, GUARD.
- IDLE -> PRE: when hold_valid = 1. At that edge the hold register loads into tx_sr, hold_valid clears, and the symbol and carrier counters clear. PRE is entered one clk after hold_valid rises.
- Symbol timing: the symbol counter runs 0..CLKS_PER_BIT-1. At terminal count, advance to the next symbol.
- PRE -> DATA after PRE_W symbols.
- DATA -> GUARD after WORD_W symbols; tx_sr shifts MSB first.
- GUARD, last clk: frame_done pulses. Next state is PRE (reloading tx_sr) if hold_valid = 1, otherwise IDLE. Back-to-back frames have no gap cycle.
- carrier_en: PREAMBLE[PRE_W-1-idx] in PRE, tx_sr MSB in DATA, 0 in GUARD and IDLE. Driven directly from state registers, so it is glitch-free.
- Carrier: a phase flip-flop toggles every CARRIER_DIV clks while not IDLE; it is held at 0 in IDLE.
- ask_out: <= phase & carrier_en, so it lags carrier_en by one clk.
- Reset mid-frame: takes effect immediately, asynchronously. The frame in flight is aborted and the held word is lost. After reset release, nothing is transmitted until the next word_start.
- Counter widths: $clog2 of the respective maxima; no wrap beyond the terminal counts.

Decomposition:
- Shared include/package ask_pkg holds:
  - FSM state encodings (IDLE=0, PRE=1, DATA=2, GUARD=3);
  - the default PREAMBLE/PRE_W constants;
  - WORD_W, shared with word_generator and xor_word.
- One natural sub-module, ask_carrier_div: carrier divider with an enable and a phase output.
- Collector, hold register, FSM and output register stay in ask_keyer.

Test Plan:
- Reset: hold rst=0 while toggling inputs -> all outputs 0. After release with no word_start -> tx_busy stays 0.
- Single word 0xA5C, CLKS_PER_BIT=4: carrier_en sequence 1010 | 101001011100 | 00, each symbol exactly 4 clks. frame_done pulses once; tx_busy falls the clk after.
- Back-to-back: second word completes during DATA of the first -> PRE follows GUARD with zero idle clks, and no overflow.
- Overflow: three words complete while the first is transmitting -> the third is dropped and overflow pulses exactly once. Frames 1 and 2 are transmitted intact.
- Restart mid-word: word_start after 5 bits, then 12 fresh bits of 0x3F0 -> only 0x3F0 is transmitted.
- Async reset in DATA symbol 6 -> outputs 0 immediately without a clk edge. The next valid word transmits normally from PRE.
